// File: rtl/delay_decoder.sv
// -----------------------------------------------------------------------------
// delay_decoder
//
// Receive-side monitor for the 4-bit delay-counter stream. Each frame of the
// stream is: 0 held D cycles (head), 1..14 one cycle each, 15 held D cycles
// (tail), then a wrap to 0, with D in 1..8. The block recovers D, locks after
// LOCK_FRAMES consecutive good frames of equal D, and flags any later protocol
// violation with a sticky error until clear or reset.
//
// Parameters:
//   LOCK_FRAMES  consecutive good, equal-D frames needed to lock (1..15)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   clear        synchronous return to SEEK; clears error and frame_cnt
//   count_in     observed 4-bit counter value
//   delay_out    recovered delay, D mod 8 (D=8 reports 0); valid while locked
//   locked       high while in LOCK
//   error        sticky violation flag, high while in ERR
//   frame_pulse  one-cycle pulse per good frame while locked
//   frame_cnt    count of good frames while locked, wraps 255 -> 0
//
// Optional feature:
//   DELAY_DECODER_STRICT_EN  when defined, any value 1..14 held for more than
//                            one cycle counts as a violation in ACQ and LOCK.
// -----------------------------------------------------------------------------
module delay_decoder #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] count_in,
  output logic [2:0] delay_out,
  output logic       locked,
  output logic       error,
  output logic       frame_pulse,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  // Stream observation registers
  logic [3:0] prev_q, prev_d;
  logic [3:0] run_len_q, run_len_d;
  logic [3:0] head_len_q, head_len_d;

  // Acquisition / lock bookkeeping
  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [3:0] d_cand_q, d_cand_d;

  // Registered outputs
  logic [2:0] delay_q, delay_d;
  logic       locked_q, locked_d;
  logic       error_q, error_d;
  logic       pulse_q, pulse_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Per-cycle stream decode
  logic       change;
  logic       step_ok;
  logic       stall;
  logic       wrap;
  logic       strict_viol;
  logic       violation;
  logic       frame_ok;
  logic [3:0] tail_len;
  logic [3:0] good_next;

  always_comb begin
    change    = (count_in != prev_q);
    step_ok   = (count_in == prev_q + 4'd1);
    run_len_d = change ? 4'd1 : ((run_len_q == 4'd15) ? 4'd15 : run_len_q + 4'd1);
    // A value held for a ninth cycle can never be legal (D <= 8 and middle
    // values are single), so it is flagged on the cycle the count reaches 9.
    stall     = (run_len_d == 4'd9);
    wrap      = (prev_q == 4'd15) && (count_in == 4'd0);
    prev_d    = count_in;
    // At the wrap the run that just ended is the tail of value 15.
    tail_len  = run_len_q;
    head_len_d = ((prev_q == 4'd0) && (count_in == 4'd1)) ? run_len_q : head_len_q;
    frame_ok  = (head_len_q == tail_len) && (tail_len >= 4'd1) && (tail_len <= 4'd8);
`ifdef DELAY_DECODER_STRICT_EN
    strict_viol = !change && (count_in >= 4'd1) && (count_in <= 4'd14);
`else
    strict_viol = 1'b0;
`endif
    // Any violation forces ACQ/LOCK out immediately, so a frame reaching a
    // wrap inside those states is by construction violation-free.
    violation = (change && !step_ok) || stall || strict_viol;
    good_next = (tail_len == d_cand_q) ? good_cnt_q + 4'd1 : 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    d_cand_d    = d_cand_q;
    delay_d     = delay_q;
    frame_cnt_d = frame_cnt_q;
    pulse_d     = 1'b0;

    if (clear) begin
      // Takes precedence over the stream, so a wrap in this cycle is dropped.
      state_d     = ST_SEEK;
      good_cnt_d  = 4'd0;
      frame_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (wrap) begin
            state_d    = ST_ACQ;
            good_cnt_d = 4'd0;
            d_cand_d   = 4'd0;  // no valid D is 0, so the first good frame restarts at 1
          end
        end
        ST_ACQ: begin
          if (violation || (wrap && !frame_ok)) begin
            state_d = ST_SEEK;
          end else if (wrap) begin
            good_cnt_d = good_next;
            d_cand_d   = tail_len;
            if (good_next == LOCK_N) begin
              state_d = ST_LOCK;
              delay_d = tail_len[2:0];
            end
          end
        end
        ST_LOCK: begin
          if (violation || (wrap && (!frame_ok || (tail_len != d_cand_q)))) begin
            state_d = ST_ERR;
          end else if (wrap) begin
            pulse_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_SEEK;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
    error_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 4'd0;
      run_len_q   <= 4'd0;
      head_len_q  <= 4'd0;
      state_q     <= ST_SEEK;
      good_cnt_q  <= 4'd0;
      d_cand_q    <= 4'd0;
      delay_q     <= 3'd0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      pulse_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      prev_q      <= prev_d;
      run_len_q   <= run_len_d;
      head_len_q  <= head_len_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      d_cand_q    <= d_cand_d;
      delay_q     <= delay_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      pulse_q     <= pulse_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign delay_out   = delay_q;
  assign locked      = locked_q;
  assign error       = error_q;
  assign frame_pulse = pulse_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_delay_decoder.sv
// -----------------------------------------------------------------------------
// tb_delay_decoder
//
// Directed scenarios followed by randomized frames. Every cycle the outputs
// are compared with a behavioural model that works on runs of the observed
// stream: it measures how long each value is held, judges each completed frame
// at the wrap, and walks through seek / acquire / lock / error modes.
// -----------------------------------------------------------------------------
module tb_delay_decoder;

  localparam int LOCK_FRAMES = 2;
`ifdef DELAY_DECODER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam int M_SEEK = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_ERR  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic [2:0] delay_out;
  logic       locked;
  logic       error;
  logic       frame_pulse;
  logic [7:0] frame_cnt;

  delay_decoder #(.LOCK_FRAMES(LOCK_FRAMES)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .count_in    (count_in),
    .delay_out   (delay_out),
    .locked      (locked),
    .error       (error),
    .frame_pulse (frame_pulse),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;
  int pulse_at[$];

  // Frame under construction, played one value per clock
  logic [3:0] fq[$];

  // Reference model state
  int         m_prev, m_run, m_head, m_mode, m_cand, m_good, m_cnt;
  logic [2:0] m_delay;
  bit         m_pulse;

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_head = 0; m_mode = M_SEEK;
    m_cand = 0; m_good = 0; m_cnt = 0; m_delay = 3'd0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input int v, input bit clr);
    bit chg, wrap, viol, good;
    int run_new, tail;
    chg     = (v != m_prev);
    run_new = chg ? 1 : ((m_run + 1 > 15) ? 15 : m_run + 1);
    wrap    = (m_prev == 15) && (v == 0);
    tail    = m_run;
    viol    = (chg && (v != (m_prev + 1) % 16)) || (run_new >= 9);
    if (STRICT && !chg && v >= 1 && v <= 14) viol = 1'b1;
    good    = (m_head == tail) && (tail >= 1) && (tail <= 8);
    if (m_prev == 0 && v == 1) m_head = m_run;
    m_pulse = 1'b0;
    if (clr) begin
      m_mode = M_SEEK;
      m_cnt  = 0;
    end else if (m_mode == M_SEEK) begin
      if (wrap) begin m_mode = M_ACQ; m_good = 0; m_cand = 0; end
    end else if (m_mode == M_ACQ) begin
      if (viol || (wrap && !good)) m_mode = M_SEEK;
      else if (wrap) begin
        m_good = (tail == m_cand) ? m_good + 1 : 1;
        m_cand = tail;
        if (m_good == LOCK_FRAMES) begin
          m_mode  = M_LOCK;
          m_delay = 3'(tail % 8);
        end
      end
    end else if (m_mode == M_LOCK) begin
      if (viol || (wrap && (!good || tail != m_cand))) m_mode = M_ERR;
      else if (wrap) begin
        m_pulse = 1'b1;
        m_cnt   = (m_cnt + 1) % 256;
      end
    end
    m_prev = v;
    m_run  = run_new;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic check_all();
    chk("locked",      {7'd0, locked},      {7'd0, m_mode == M_LOCK});
    chk("error",       {7'd0, error},       {7'd0, m_mode == M_ERR});
    chk("delay_out",   {5'd0, delay_out},   {5'd0, m_delay});
    chk("frame_pulse", {7'd0, frame_pulse}, {7'd0, m_pulse});
    chk("frame_cnt",   frame_cnt,           8'(m_cnt));
  endtask

  task automatic cyc(input logic [3:0] v);
    count_in = v;
    @(posedge clk);
    model_step(int'(v), clear);
    #1;
    cyc_no++;
    vectors++;
    check_all();
    if (frame_pulse === 1'b1) pulse_at.push_back(cyc_no);
  endtask

  task automatic make_frame(input int h, input int t);
    fq.delete();
    for (int i = 0; i < h; i++) fq.push_back(4'd0);
    for (int v = 1; v <= 14; v++) fq.push_back(4'(v));
    for (int i = 0; i < t; i++) fq.push_back(4'd15);
  endtask

  // Play the current frame; clr_idx selects the element sampled with clear high.
  task automatic play(input int clr_idx);
    for (int i = 0; i < fq.size(); i++) begin
      clear = (i == clr_idx);
      cyc(fq[i]);
    end
    clear = 1'b0;
  endtask

  task automatic frames(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      make_frame(d, d);
      play(-1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    check_all();
    @(posedge clk);
    #1;
    vectors++;
    check_all();
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_error",  {7'd0, error},  8'd0);
    chk("rst_cnt",    frame_cnt,      8'd0);
    chk("rst_delay",  {5'd0, delay_out}, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_cur;
    model_reset();
    #1;
    do_reset();

    // D=3 lock: first wrap aligns, lock on the third
    frames(3, 5);
    $display("step d3_lock: locked=%0b delay=%0d cnt=%0d", locked, delay_out, frame_cnt);
    chk("d3_locked", {7'd0, locked}, 8'd1);
    chk("d3_delay",  {5'd0, delay_out}, 8'd3);
    chk("d3_cnt",    frame_cnt, 8'd1);

    // Tail of 4 while locked at 3, error stays until clear
    make_frame(3, 4); play(-1);
    frames(3, 2);
    $display("step tail4: locked=%0b error=%0b", locked, error);
    chk("tail4_error",  {7'd0, error},  8'd1);
    chk("tail4_locked", {7'd0, locked}, 8'd0);
    chk("tail4_delay",  {5'd0, delay_out}, 8'd3);

    // Clear on a wrap cycle, then three wraps relock
    make_frame(3, 3); play(0);
    chk("clr_error", {7'd0, error}, 8'd0);
    frames(3, 3);
    $display("step relock: locked=%0b cnt=%0d", locked, frame_cnt);
    chk("relock", {7'd0, locked}, 8'd1);
    chk("relock_cnt", frame_cnt, 8'd0);

    // Jump 5 -> 9 while locked
    make_frame(3, 3);
    for (int i = 0; i < 3; i++) fq.delete(3 + 5);
    play(-1);
    $display("step jump: error=%0b", error);
    chk("jump_error", {7'd0, error}, 8'd1);

    // D=8 stream: delay_out 0, 30-cycle pulse spacing
    make_frame(8, 8); play(0);
    pulse_at.delete();
    frames(8, 6);
    $display("step d8: locked=%0b delay=%0d pulses=%0d", locked, delay_out, pulse_at.size());
    chk("d8_locked", {7'd0, locked}, 8'd1);
    chk("d8_delay",  {5'd0, delay_out}, 8'd0);
    chk("d8_npulse", 8'(pulse_at.size() >= 2), 8'd1);
    if (pulse_at.size() >= 2) chk("d8_spacing", 8'(pulse_at[1] - pulse_at[0]), 8'd30);

    // ACQ: D=2, then D=5, D=5 -> lock on 5
    make_frame(4, 4); play(0);
    frames(2, 1);
    frames(5, 2);
    frames(3, 1);
    $display("step acq25: locked=%0b delay=%0d", locked, delay_out);
    chk("acq_locked", {7'd0, locked}, 8'd1);
    chk("acq_delay",  {5'd0, delay_out}, 8'd5);

    // Stall on 7 for 9 cycles in ACQ -> SEEK without error
    make_frame(3, 3); play(0);
    frames(3, 1);
    make_frame(3, 3);
    for (int i = 0; i < 8; i++) fq.insert(3 + 6, 4'd7);
    play(-1);
    $display("step stall7: locked=%0b error=%0b", locked, error);
    chk("stall_locked", {7'd0, locked}, 8'd0);
    chk("stall_error",  {7'd0, error},  8'd0);

    // Value 6 held two cycles while locked
    frames(3, 3);
    make_frame(3, 3);
    fq.insert(3 + 5, 4'd6);
    play(-1);
    frames(3, 1);
    $display("step hold6: error=%0b strict=%0b", error, STRICT);
    chk("hold6_error", {7'd0, error}, {7'd0, STRICT});

    // Reset mid-frame
    make_frame(3, 3);
    for (int i = 0; i < 10; i++) cyc(fq[i]);
    do_reset();

    // Randomized frames
    d_cur = 3;
    for (int f = 0; f < 150; f++) begin
      int t, kind, k, clr_idx;
      if ($urandom_range(0, 5) == 0) d_cur = $urandom_range(1, 8);
      t = d_cur;
      kind = $urandom_range(0, 19);
      clr_idx = -1;
      if (kind == 0) t = (d_cur == 8) ? 7 : d_cur + 1;
      if (kind == 1) make_frame(9, 9);
      else make_frame(d_cur, t);
      k = d_cur + $urandom_range(0, 13);
      case (kind)
        2: fq.insert(k, fq[k]);
        3: fq.delete(k);
        4: for (int i = 0; i < 8; i++) fq.insert(k, fq[k]);
        5: clr_idx = $urandom_range(0, 15);
        default: ;
      endcase
      play(clr_idx);
      $display("frame %0d: D=%0d tail=%0d kind=%0d locked=%0b error=%0b cnt=%0d",
               f, d_cur, t, kind, locked, error, frame_cnt);
      if (error === 1'b1 && $urandom_range(0, 2) == 0) begin
        make_frame(d_cur, d_cur);
        play(0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
